// File: rtl/a_ext_defs.sv
// rtl/a_ext_defs.sv - shared types for the atomic memory operation unit
// Contents: amo_ops enum, LSU<->AMO data/control structs, FSM state enum,
//           and a helper that tells whether an operation touches memory.
package a_ext_defs;

   typedef enum logic [3:0] {
      AMO_OPS_NONE = 4'd0,
      AMO_OPS_LR   = 4'd1,
      AMO_OPS_SC   = 4'd2,
      AMO_OPS_SWAP = 4'd3,
      AMO_OPS_ADD  = 4'd4,
      AMO_OPS_XOR  = 4'd5,
      AMO_OPS_AND  = 4'd6,
      AMO_OPS_OR   = 4'd7,
      AMO_OPS_MIN  = 4'd8,
      AMO_OPS_MAX  = 4'd9,
      AMO_OPS_MINU = 4'd10,
      AMO_OPS_MAXU = 4'd11
   } type_amo_ops_e;

   typedef enum logic [1:0] {
      AMO_IDLE  = 2'd0,
      AMO_LOAD  = 2'd1,
      AMO_STORE = 2'd2,
      AMO_DONE  = 2'd3
   } type_amo_state_e;

   typedef struct packed {
      logic [31:0] r_data;
      logic [31:0] rs2_operand;
      logic [31:0] lsu_addr;
   } type_lsu2amo_data_s;

   typedef struct packed {
      logic          is_amo;
      type_amo_ops_e amo_ops;
      logic          ack;
   } type_lsu2amo_ctrl_s;

   typedef struct packed {
      logic [31:0] lsu_addr;
      logic [31:0] w_data;
      logic [31:0] rd_result;
   } type_amo2lsu_data_s;

   typedef struct packed {
      logic rd_req;
      logic wr_req;
      logic done;
   } type_amo2lsu_ctrl_s;

   // NONE and the unused encodings above MAXU complete without any access.
   function automatic logic is_mem_op(input type_amo_ops_e op);
      return (op >= AMO_OPS_LR) && (op <= AMO_OPS_MAXU);
   endfunction

endpackage

// File: rtl/amo.sv
// rtl/amo.sv - atomic memory operation sequencer (LR/SC and read-modify-write AMOs)
// Ports:
//   clk            - clock, rising edge
//   rst_n          - asynchronous reset, active high
//   lsu2amo_data_i - read data, rs2 operand, word address
//   lsu2amo_ctrl_i - start request, operation, memory acknowledge
//   amo2lsu_data_o - access address, store data, rd result
//   amo2lsu_ctrl_o - read request, write request, one-cycle done pulse
module amo
   import a_ext_defs::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  type_lsu2amo_data_s lsu2amo_data_i,
   input  type_lsu2amo_ctrl_s lsu2amo_ctrl_i,
   output type_amo2lsu_data_s amo2lsu_data_o,
   output type_amo2lsu_ctrl_s amo2lsu_ctrl_o
);

   type_amo_state_e state_ff;
   type_amo_ops_e   op_ff;
   logic [31:0]     addr_ff;
   logic [31:0]     rs2_ff;
   logic [31:0]     w_data_ff;
   logic [31:0]     rd_result_ff;
   logic            rd_req_ff;
   logic            wr_req_ff;
   logic            done_ff;

   logic            reservation_valid_ff;
   logic [31:0]     reservation_addr_ff;
   logic [31:0]     amo_buffer_data_ff;

   logic [31:0]     alu_res;
   logic            sc_success;

   // Read-modify-write result; ties on MIN/MAX keep the memory value.
   always_comb begin
      alu_res = lsu2amo_data_i.r_data;
      case (op_ff)
         AMO_OPS_SWAP: alu_res = rs2_ff;
         AMO_OPS_ADD:  alu_res = lsu2amo_data_i.r_data + rs2_ff;
         AMO_OPS_XOR:  alu_res = lsu2amo_data_i.r_data ^ rs2_ff;
         AMO_OPS_AND:  alu_res = lsu2amo_data_i.r_data & rs2_ff;
         AMO_OPS_OR:   alu_res = lsu2amo_data_i.r_data | rs2_ff;
         AMO_OPS_MIN:  alu_res = ($signed(rs2_ff) < $signed(lsu2amo_data_i.r_data)) ? rs2_ff : lsu2amo_data_i.r_data;
         AMO_OPS_MAX:  alu_res = ($signed(rs2_ff) > $signed(lsu2amo_data_i.r_data)) ? rs2_ff : lsu2amo_data_i.r_data;
         AMO_OPS_MINU: alu_res = (rs2_ff < lsu2amo_data_i.r_data) ? rs2_ff : lsu2amo_data_i.r_data;
         AMO_OPS_MAXU: alu_res = (rs2_ff > lsu2amo_data_i.r_data) ? rs2_ff : lsu2amo_data_i.r_data;
         default:      alu_res = lsu2amo_data_i.r_data;
      endcase
   end

   // SC also requires the memory word to still hold the value LR observed.
   assign sc_success = reservation_valid_ff && (reservation_addr_ff == addr_ff) &&
                       (amo_buffer_data_ff == lsu2amo_data_i.r_data);

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_ff             <= AMO_IDLE;
         op_ff                <= AMO_OPS_NONE;
         addr_ff              <= '0;
         rs2_ff               <= '0;
         w_data_ff            <= '0;
         rd_result_ff         <= '0;
         rd_req_ff            <= 1'b0;
         wr_req_ff            <= 1'b0;
         done_ff              <= 1'b0;
         reservation_valid_ff <= 1'b0;
         reservation_addr_ff  <= '0;
         amo_buffer_data_ff   <= '0;
      end else begin
         case (state_ff)
            AMO_IDLE: begin
               done_ff <= 1'b0;
               if (lsu2amo_ctrl_i.is_amo) begin
                  addr_ff <= lsu2amo_data_i.lsu_addr;
                  rs2_ff  <= lsu2amo_data_i.rs2_operand;
                  op_ff   <= lsu2amo_ctrl_i.amo_ops;
                  if (is_mem_op(lsu2amo_ctrl_i.amo_ops)) begin
                     rd_req_ff <= 1'b1;
                     state_ff  <= AMO_LOAD;
                  end else begin
                     rd_result_ff <= '0;
                     done_ff      <= 1'b1;
                     state_ff     <= AMO_DONE;
                  end
               end
            end
            AMO_LOAD: begin
               if (lsu2amo_ctrl_i.ack) begin
                  rd_req_ff <= 1'b0;
                  case (op_ff)
                     AMO_OPS_LR: begin
                        reservation_addr_ff  <= addr_ff;
                        amo_buffer_data_ff   <= lsu2amo_data_i.r_data;
                        reservation_valid_ff <= 1'b1;
                        rd_result_ff         <= lsu2amo_data_i.r_data;
                        done_ff              <= 1'b1;
                        state_ff             <= AMO_DONE;
                     end
                     AMO_OPS_SC: begin
                        reservation_valid_ff <= 1'b0;
                        if (sc_success) begin
                           w_data_ff    <= rs2_ff;
                           rd_result_ff <= '0;
                           wr_req_ff    <= 1'b1;
                           state_ff     <= AMO_STORE;
                        end else begin
                           rd_result_ff <= 32'd1;
                           done_ff      <= 1'b1;
                           state_ff     <= AMO_DONE;
                        end
                     end
                     default: begin
                        rd_result_ff <= lsu2amo_data_i.r_data;
                        w_data_ff    <= alu_res;
                        wr_req_ff    <= 1'b1;
                        state_ff     <= AMO_STORE;
                     end
                  endcase
               end
            end
            AMO_STORE: begin
               if (lsu2amo_ctrl_i.ack) begin
                  wr_req_ff <= 1'b0;
                  done_ff   <= 1'b1;
                  state_ff  <= AMO_DONE;
                  // Another hart-visible write to the reserved word breaks the reservation.
                  if ((op_ff != AMO_OPS_SC) && (addr_ff == reservation_addr_ff))
                     reservation_valid_ff <= 1'b0;
               end
            end
            default: begin
               done_ff  <= 1'b0;
               state_ff <= AMO_IDLE;
            end
         endcase
      end
   end

   assign amo2lsu_data_o.lsu_addr  = addr_ff;
   assign amo2lsu_data_o.w_data    = w_data_ff;
   assign amo2lsu_data_o.rd_result = rd_result_ff;
   assign amo2lsu_ctrl_o.rd_req    = rd_req_ff;
   assign amo2lsu_ctrl_o.wr_req    = wr_req_ff;
   assign amo2lsu_ctrl_o.done      = done_ff;

endmodule

// File: tb/tb_amo.sv
// tb/tb_amo.sv - self-checking bench for amo with a behavioural memory/reservation model
module tb_amo;
   import a_ext_defs::*;

   logic               clk;
   logic               rst_n;
   type_lsu2amo_data_s d_i;
   type_lsu2amo_ctrl_s c_i;
   type_amo2lsu_data_s d_o;
   type_amo2lsu_ctrl_s c_o;

   int checks;
   int failures;

   logic [31:0] mem [logic [31:0]];
   bit          m_res_valid;
   logic [31:0] m_res_addr;
   logic [31:0] m_res_data;

   amo dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .lsu2amo_data_i (d_i),
      .lsu2amo_ctrl_i (c_i),
      .amo2lsu_data_o (d_o),
      .amo2lsu_ctrl_o (c_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0;
   endfunction

   // Reference: what the operation should return and store, from the ISA rules.
   function automatic logic [31:0] ref_f(input type_amo_ops_e op, input logic [31:0] m, input logic [31:0] s);
      int signed sm, ss;
      sm = m;
      ss = s;
      case (op)
         AMO_OPS_SWAP: return s;
         AMO_OPS_ADD:  return 32'((64'(m) + 64'(s)) % 64'h1_0000_0000);
         AMO_OPS_XOR:  return m ^ s;
         AMO_OPS_AND:  return m & s;
         AMO_OPS_OR:   return m | s;
         AMO_OPS_MIN:  return (sm <= ss) ? m : s;
         AMO_OPS_MAX:  return (sm >= ss) ? m : s;
         AMO_OPS_MINU: return (m <= s) ? m : s;
         AMO_OPS_MAXU: return (m >= s) ? m : s;
         default:      return m;
      endcase
   endfunction

   task automatic do_op(input type_amo_ops_e op, input logic [31:0] addr, input logic [31:0] rs2,
                        input bit always_ack);
      logic [31:0] r, exp_rd, exp_w;
      bit          exp_read, exp_write, saw_rd, saw_wr, got_done;
      int          cyc, exp_lat;

      r         = mem_rd(addr);
      exp_read  = (int'(op) >= 1) && (int'(op) <= 11);
      exp_write = 1'b0;
      exp_rd    = 32'h0;
      exp_w     = 32'h0;
      if (!exp_read) begin
         exp_rd = 32'h0;
      end else if (op == AMO_OPS_LR) begin
         exp_rd      = r;
         m_res_valid = 1'b1;
         m_res_addr  = addr;
         m_res_data  = r;
      end else if (op == AMO_OPS_SC) begin
         if (m_res_valid && m_res_addr == addr && m_res_data == r) begin
            exp_write = 1'b1;
            exp_w     = rs2;
            exp_rd    = 32'h0;
         end else begin
            exp_rd = 32'h1;
         end
         m_res_valid = 1'b0;
      end else begin
         exp_write = 1'b1;
         exp_w     = ref_f(op, r, rs2);
         exp_rd    = r;
         if (m_res_valid && m_res_addr == addr) m_res_valid = 1'b0;
      end
      exp_lat = !exp_read ? 1 : (exp_write ? 3 : 2);

      @(negedge clk);
      chk("done_idle_low", 32'(c_o.done), 32'h0);
      c_i.is_amo      = 1'b1;
      c_i.amo_ops     = op;
      d_i.lsu_addr    = addr;
      d_i.rs2_operand = rs2;
      c_i.ack         = always_ack;
      @(posedge clk);
      #1;
      c_i.is_amo      = 1'b0;
      d_i.lsu_addr    = $urandom;
      d_i.rs2_operand = $urandom;
      c_i.amo_ops     = type_amo_ops_e'($urandom_range(0, 11));

      saw_rd = 0; saw_wr = 0; got_done = 0; cyc = 0;
      while (!got_done && cyc < 64) begin
         @(negedge clk);
         cyc++;
         if (c_o.rd_req && c_o.wr_req) chk("rd_wr_overlap", 32'h1, 32'h0);
         if (c_o.done) begin
            got_done = 1;
            c_i.ack  = 1'b0;
            chk("rd_result", d_o.rd_result, exp_rd);
            if (always_ack) chk("latency", 32'(cyc), 32'(exp_lat));
         end else if (c_o.rd_req) begin
            saw_rd     = 1;
            d_i.r_data = mem_rd(d_o.lsu_addr);
            c_i.ack    = always_ack ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (c_i.ack) chk("rd_addr", d_o.lsu_addr, addr);
         end else if (c_o.wr_req) begin
            saw_wr     = 1;
            d_i.r_data = $urandom;
            c_i.ack    = always_ack ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (c_i.ack) begin
               chk("wr_addr", d_o.lsu_addr, addr);
               chk("w_data", d_o.w_data, exp_w);
               mem[d_o.lsu_addr] = d_o.w_data;
            end
         end else begin
            c_i.ack = 1'b0;
         end
      end
      chk("op_completed", 32'(got_done), 32'h1);
      chk("read_issued", 32'(saw_rd), 32'(exp_read));
      chk("write_issued", 32'(saw_wr), 32'(exp_write));
      @(negedge clk);
      chk("done_one_cycle", 32'(c_o.done), 32'h0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_req"}, 32'(c_o.rd_req), 32'h0);
      chk({tag, "_wr_req"}, 32'(c_o.wr_req), 32'h0);
      chk({tag, "_done"}, 32'(c_o.done), 32'h0);
      chk({tag, "_lsu_addr"}, d_o.lsu_addr, 32'h0);
      chk({tag, "_w_data"}, d_o.w_data, 32'h0);
      chk({tag, "_rd_result"}, d_o.rd_result, 32'h0);
      chk({tag, "_state"}, 32'(dut.state_ff), 32'(AMO_IDLE));
      chk({tag, "_res_valid"}, 32'(dut.reservation_valid_ff), 32'h0);
   endtask

   initial begin
      logic [31:0] addrs [4];
      logic [31:0] rs2_pick;
      type_amo_ops_e op;
      int sel;

      checks = 0; failures = 0;
      m_res_valid = 0; m_res_addr = 0; m_res_data = 0;
      addrs[0] = 32'h1000; addrs[1] = 32'h1004; addrs[2] = 32'h2000; addrs[3] = 32'h2004;
      d_i = '0;
      c_i = '0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      chk("reset_buffer", dut.amo_buffer_data_ff, 32'h0);
      chk("reset_res_addr", dut.reservation_addr_ff, 32'h0);
      rst_n = 1'b0;

      // LR then successful SC
      mem[32'h1000] = 32'hDEADBEEF;
      do_op(AMO_OPS_LR, 32'h1000, 32'h0, 1'b1);
      chk("lr_res_valid", 32'(dut.reservation_valid_ff), 32'h1);
      chk("lr_buffer", dut.amo_buffer_data_ff, 32'hDEADBEEF);
      do_op(AMO_OPS_SC, 32'h1000, 32'h12345678, 1'b1);
      chk("sc_mem", mem_rd(32'h1000), 32'h12345678);
      chk("sc_res_cleared", 32'(dut.reservation_valid_ff), 32'h0);

      // LR then a corrupted buffer makes the SC fail
      mem[32'h1000] = 32'hDEADBEEF;
      do_op(AMO_OPS_LR, 32'h1000, 32'h0, 1'b1);
      force dut.amo_buffer_data_ff = 32'hBADBEEF0;
      m_res_data = 32'hBADBEEF0;
      do_op(AMO_OPS_SC, 32'h1000, 32'h12345678, 1'b1);
      release dut.amo_buffer_data_ff;
      chk("sc_fail_mem", mem_rd(32'h1000), 32'hDEADBEEF);

      // ALU corner cases
      mem[32'h3000] = 32'hFFFFFFFF;
      do_op(AMO_OPS_ADD, 32'h3000, 32'h1, 1'b1);
      chk("add_wrap", mem_rd(32'h3000), 32'h0);
      mem[32'h3004] = 32'h80000000;
      do_op(AMO_OPS_MIN, 32'h3004, 32'h1, 1'b1);
      chk("min_signed", mem_rd(32'h3004), 32'h80000000);
      mem[32'h3008] = 32'h80000000;
      do_op(AMO_OPS_MINU, 32'h3008, 32'h1, 1'b1);
      chk("minu", mem_rd(32'h3008), 32'h1);
      do_op(AMO_OPS_NONE, 32'h3008, 32'h5, 1'b1);
      do_op(type_amo_ops_e'(4'd14), 32'h3008, 32'h5, 1'b1);

      // ack withheld in LOAD, then reset mid-operation
      @(negedge clk);
      c_i.is_amo = 1'b1; c_i.amo_ops = AMO_OPS_ADD; c_i.ack = 1'b0;
      d_i.lsu_addr = 32'h2000; d_i.rs2_operand = 32'h7;
      @(posedge clk);
      #1 c_i.is_amo = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_rd_req", 32'(c_o.rd_req), 32'h1);
         chk("stall_no_done", 32'(c_o.done), 32'h0);
      end
      #2 rst_n = 1'b1;
      #1 chk_reset_outputs("midreset");
      @(negedge clk);
      chk_reset_outputs("midreset_hold");
      rst_n = 1'b0;
      m_res_valid = 0;

      // Randomised sequences over a small address pool to exercise reservations
      for (int n = 0; n < 250; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 3)      op = AMO_OPS_LR;
         else if (sel < 5) op = AMO_OPS_SC;
         else              op = type_amo_ops_e'($urandom_range(0, 15));
         case ($urandom_range(0, 4))
            0:       rs2_pick = 32'h0;
            1:       rs2_pick = 32'hFFFFFFFF;
            2:       rs2_pick = 32'h80000000;
            default: rs2_pick = $urandom;
         endcase
         do_op(op, addrs[$urandom_range(0, 3)], rs2_pick, ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/amo.md
AMO -- requirements
Module: amo

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-high (asserted when rst_n=1).
REQ-003 lsu2amo_data_i  input  struct  r_data[31:0] memory read data; rs2_operand[31:0] source operand; lsu_addr[31:0] word address.
REQ-004 lsu2amo_ctrl_i  input  struct  is_amo start request; amo_ops operation enum; ack memory-access acknowledge.
REQ-005 amo2lsu_data_o  output  struct  lsu_addr[31:0] access address; w_data[31:0] store data; rd_result[31:0] value for rd.
REQ-006 amo2lsu_ctrl_o  output  struct  rd_req memory read request; wr_req memory write request; done one-cycle completion pulse.
REQ-007 amo_ops enum values: AMO_OPS_NONE, AMO_OPS_LR, AMO_OPS_SC, AMO_OPS_SWAP, AMO_OPS_ADD, AMO_OPS_XOR, AMO_OPS_AND, AMO_OPS_OR, AMO_OPS_MIN, AMO_OPS_MAX, AMO_OPS_MINU, AMO_OPS_MAXU.

Function
REQ-008 FSM states IDLE, LOAD, STORE, DONE; reset state IDLE.
REQ-009 IDLE: when is_amo=1, register lsu_addr, rs2_operand, amo_ops; next state LOAD; otherwise stay IDLE.
REQ-010 LOAD: rd_req=1, lsu_addr driven from registered address; stay until ack=1.
REQ-011 LOAD with ack, op LR: reservation_addr_ff<=addr, amo_buffer_data_ff<=r_data, reservation_valid_ff<=1, rd_result<=r_data; next DONE.
REQ-012 LOAD with ack, op SC: success iff reservation_valid_ff=1, reservation_addr_ff=addr and amo_buffer_data_ff=r_data; success -> w_data<=rs2, rd_result<=0, next STORE; failure -> rd_result<=1, next DONE, no write.
REQ-013 SC clears reservation_valid_ff on leaving LOAD, success or failure.
REQ-014 LOAD with ack, other ops: rd_result<=r_data (old value); w_data<=f(r_data, rs2); next STORE.
REQ-015 f: SWAP=rs2; ADD=r_data+rs2 (32-bit wrap, carry discarded); XOR/AND/OR bitwise; MIN/MAX signed compare; MINU/MAXU unsigned compare; equal operands select r_data.
REQ-016 STORE: wr_req=1 with w_data and lsu_addr held; stay until ack=1; next DONE.
REQ-017 Non-SC store to reservation_addr_ff clears reservation_valid_ff when STORE completes.
REQ-018 DONE: done=1 for exactly one cycle, rd_result valid; next IDLE.
REQ-019 rd_req and wr_req never asserted together; both 0 in IDLE and DONE.
REQ-020 Inputs sampled only in IDLE; changes during LOAD/STORE ignored; is_amo held high restarts a new operation after DONE.
REQ-021 AMO_OPS_NONE or undefined op with is_amo=1: no memory access, rd_result=0, go directly to DONE.
REQ-022 Latency with ack tied high: LR/failed SC 3 cycles from IDLE sample to done; write ops 4 cycles.

Reset
REQ-023 Reset asynchronously forces state IDLE; rd_req, wr_req, done=0; lsu_addr, w_data, rd_result=0.
REQ-024 Reset clears reservation_valid_ff, reservation_addr_ff, amo_buffer_data_ff to 0.
REQ-025 Reset mid-operation aborts without issuing further requests; release resumes in IDLE.

Structure
REQ-026 Struct types type_lsu2amo_data_s, type_lsu2amo_ctrl_s, type_amo2lsu_data_s, type_amo2lsu_ctrl_s and the amo_ops enum live in the shared a_ext_defs header/package.
REQ-027 Single module, no sub-modules; ALU of REQ-015 as combinational block; register named amo_buffer_data_ff (bench accesses it hierarchically).

Verification
REQ-028 LR: addr 0x1000, r_data 0xDEADBEEF, ack=1 -> rd_result 0xDEADBEEF, reservation valid, amo_buffer_data_ff 0xDEADBEEF, done pulse.
REQ-029 SC after LR, same addr, r_data 0xDEADBEEF, rs2 0x12345678 -> wr_req with w_data 0x12345678, rd_result 0, reservation cleared.
REQ-030 LR then amo_buffer_data_ff forced to 0xBADBEEF0, SC -> no wr_req, rd_result 1.
REQ-031 AMOADD r_data 0xFFFFFFFF, rs2 1 -> w_data 0, rd_result 0xFFFFFFFF; AMOMIN 0x80000000 vs 1 -> w_data 0x80000000; AMOMINU -> 1.
REQ-032 ack held low in LOAD for 5 cycles -> rd_req stays 1, no done; reset asserted mid-LOAD -> all outputs 0, state IDLE.
